// File: rtl/seq_decoder_if.sv
// rtl/seq_decoder_if.sv - command/output bundle for seq_decoder; scan pins exist only with SEQ_DECODER_SCAN_EN
interface seq_decoder_if #(
    parameter int ADDR_W = 2
);
    localparam int OUT_W = 1 << ADDR_W;

    logic              in_valid;
    logic              in_ready;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [OUT_W-1:0]  out;
    logic              out_valid;
    logic              busy;

`ifdef SEQ_DECODER_SCAN_EN
    logic              scan_start;
    logic              scan_stop;

    modport master (
        output in_valid, en, addr, scan_start, scan_stop,
        input  in_ready, out, out_valid, busy
    );

    modport slave (
        input  in_valid, en, addr, scan_start, scan_stop,
        output in_ready, out, out_valid, busy
    );
`else
    modport master (
        output in_valid, en, addr,
        input  in_ready, out, out_valid, busy
    );

    modport slave (
        input  in_valid, en, addr,
        output in_ready, out, out_valid, busy
    );
`endif
endinterface

// File: rtl/seq_decoder.sv
// rtl/seq_decoder.sv - registered N-to-2^N one-hot decoder with valid/ready command; scan walker under SEQ_DECODER_SCAN_EN
module seq_decoder #(
    parameter int ADDR_W     = 2,
    parameter int SCAN_DWELL = 4
) (
    input  logic         clk,
    input  logic         reset,
    seq_decoder_if.slave bus
);
    localparam int OUT_W = 1 << ADDR_W;
    localparam logic [OUT_W-1:0] ONE_HOT_0 = OUT_W'(1);

    if (SCAN_DWELL < 1 || SCAN_DWELL > 255) begin : g_bad_dwell
        $error("SCAN_DWELL must be within 1..255");
    end

    logic             accept;
    logic [OUT_W-1:0] decode;
    logic [OUT_W-1:0] out_q;
    logic             out_valid_q;

    assign accept        = bus.in_valid && bus.in_ready;
    assign decode        = bus.en ? (ONE_HOT_0 << bus.addr) : '0;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

`ifdef SEQ_DECODER_SCAN_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;
    localparam logic [7:0] DWELL_LAST = 8'(SCAN_DWELL - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        dwell;
    logic              scan_go;

    // start+stop together is a no-op; scan_start alone also blocks direct accepts
    assign scan_go      = bus.scan_start && !bus.scan_stop;
    assign bus.in_ready = !reset && (state == ST_IDLE) && !bus.scan_start;
    assign bus.busy     = (state == ST_SCAN);

    // FSM, scan counters and output register; out always reflects the idx/dwell position just reached
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            dwell       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= accept;
            if (state == ST_IDLE) begin
                if (scan_go) begin
                    state <= ST_SCAN;
                    idx   <= '0;
                    dwell <= '0;
                    out_q <= ONE_HOT_0;
                end else if (accept) begin
                    out_q <= decode;
                end
            end else begin
                if (bus.scan_stop) begin
                    state <= ST_IDLE;
                    out_q <= '0;
                end else if (!bus.en) begin
                    // paused: blank the lines, keep position so the dwell resumes where it left off
                    out_q <= '0;
                end else if (dwell == DWELL_LAST) begin
                    dwell <= '0;
                    idx   <= idx + 1'b1;
                    out_q <= ONE_HOT_0 << (idx + 1'b1);
                end else begin
                    dwell <= dwell + 8'd1;
                    out_q <= ONE_HOT_0 << idx;
                end
            end
        end
    end
`else
    assign bus.in_ready = !reset;
    assign bus.busy     = 1'b0;

    // direct decode only: load out on accept, hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                out_q <= decode;
            end
        end
    end
`endif
endmodule

// File: tb/tb_seq_decoder.sv
// tb/tb_seq_decoder.sv - directed table-driven bench for seq_decoder (ADDR_W=2 and ADDR_W=3 instances)
module tb_seq_decoder;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pos;

    always #5 clk = ~clk;

    seq_decoder_if #(.ADDR_W(2)) bus2 ();
    seq_decoder_if #(.ADDR_W(3)) bus3 ();

    seq_decoder #(.ADDR_W(2), .SCAN_DWELL(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
    seq_decoder #(.ADDR_W(3), .SCAN_DWELL(4)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    typedef struct {
        logic       in_valid;
        logic       en;
        logic [1:0] addr;
        logic [3:0] exp_out;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] scan_exp(input int p);
        logic [3:0] one;
        one = 4'b0001;
        return one << ((p / 4) % 4);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'd1, 4'b0000, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 2'd1, 4'b0000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'd2, 4'b0000, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 2'd2, 4'b0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'd3, 4'b0000, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 2'd3, 4'b0000, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 2'd0, 4'b0001, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 2'd2, 4'b0100, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 2'd3, 4'b1000, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 2'd1, 4'b1000, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 2'd2, 4'b1000, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 2'd2, 4'b0100, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 2'd1, 4'b0000, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 2'd3, 4'b0000, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};

        reset = 1'b1;
        bus2.in_valid = 1'b0; bus2.en = 1'b0; bus2.addr = '0;
        bus3.in_valid = 1'b0; bus3.en = 1'b0; bus3.addr = '0;
`ifdef SEQ_DECODER_SCAN_EN
        bus2.scan_start = 1'b0; bus2.scan_stop = 1'b0;
        bus3.scan_start = 1'b0; bus3.scan_stop = 1'b0;
`endif
        tick;
        tick;
        check("reset_in_ready", 32'(bus2.in_ready), 32'd0);
        check("reset_out", 32'(bus2.out), 32'd0);
        check("reset_out_valid", 32'(bus2.out_valid), 32'd0);
        check("reset_busy", 32'(bus2.busy), 32'd0);
        check("reset_out3", 32'(bus3.out), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(bus2.in_ready), 32'd1);

        for (int i = 0; i < 18; i++) begin
            bus2.in_valid = vecs[i].in_valid;
            bus2.en       = vecs[i].en;
            bus2.addr     = vecs[i].addr;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(bus2.in_ready), 32'd1);
            tick;
            check($sformatf("vec%0d_out", i), 32'(bus2.out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_valid", i), 32'(bus2.out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_busy", i), 32'(bus2.busy), 32'd0);
        end

        // reset while a direct command is being accepted
        bus2.in_valid = 1'b1; bus2.en = 1'b1; bus2.addr = 2'd3;
        tick;
        check("pre_reset_out", 32'(bus2.out), 32'h8);
        reset = 1'b1;
        #1;
        check("ready_in_reset", 32'(bus2.in_ready), 32'd0);
        tick;
        check("direct_reset_out", 32'(bus2.out), 32'd0);
        check("direct_reset_valid", 32'(bus2.out_valid), 32'd0);
        reset = 1'b0;
        bus2.in_valid = 1'b0;
        tick;

        // ADDR_W=3 instance: decode and hold
        bus3.in_valid = 1'b1; bus3.en = 1'b1; bus3.addr = 3'd5;
        tick;
        check("w3_out", 32'(bus3.out), 32'h20);
        check("w3_valid", 32'(bus3.out_valid), 32'd1);
        bus3.in_valid = 1'b0; bus3.addr = 3'd2;
        for (int k = 0; k < 10; k++) begin
            tick;
            check($sformatf("w3_hold%0d_out", k), 32'(bus3.out), 32'h20);
            check($sformatf("w3_hold%0d_valid", k), 32'(bus3.out_valid), 32'd0);
        end

`ifdef SEQ_DECODER_SCAN_EN
        // scan walk with wrap; in_valid held high to prove commands are blocked
        bus2.en = 1'b1; bus2.in_valid = 1'b1; bus2.addr = 2'd2;
        bus2.scan_start = 1'b1;
        #1;
        check("scan_start_blocks_ready", 32'(bus2.in_ready), 32'd0);
        tick;
        bus2.scan_start = 1'b0;
        pos = 0;
        check("scan_entry_out", 32'(bus2.out), 32'(scan_exp(pos)));
        check("scan_entry_busy", 32'(bus2.busy), 32'd1);
        for (int k = 1; k <= 17; k++) begin
            tick;
            pos++;
            check($sformatf("scan%0d_out", k), 32'(bus2.out), 32'(scan_exp(pos)));
            check($sformatf("scan%0d_valid", k), 32'(bus2.out_valid), 32'd0);
            check($sformatf("scan%0d_ready", k), 32'(bus2.in_ready), 32'd0);
        end

        // pause mid-dwell, then resume at the same position
        bus2.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            check($sformatf("pause%0d_out", k), 32'(bus2.out), 32'd0);
            check($sformatf("pause%0d_busy", k), 32'(bus2.busy), 32'd1);
        end
        bus2.en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            pos++;
            check($sformatf("resume%0d_out", k), 32'(bus2.out), 32'(scan_exp(pos)));
        end
        bus2.scan_start = 1'b1;
        tick;
        pos++;
        bus2.scan_start = 1'b0;
        check("restart_ignored_out", 32'(bus2.out), 32'(scan_exp(pos)));
        check("restart_ignored_busy", 32'(bus2.busy), 32'd1);

        // stop
        bus2.scan_stop = 1'b1;
        tick;
        bus2.scan_stop = 1'b0;
        bus2.in_valid = 1'b0;
        check("stop_out", 32'(bus2.out), 32'd0);
        check("stop_busy", 32'(bus2.busy), 32'd0);
        check("stop_valid", 32'(bus2.out_valid), 32'd0);
        check("stop_ready", 32'(bus2.in_ready), 32'd1);

        // start and stop together in IDLE
        bus2.scan_start = 1'b1; bus2.scan_stop = 1'b1;
        #1;
        check("pair_ready", 32'(bus2.in_ready), 32'd0);
        tick;
        bus2.scan_start = 1'b0; bus2.scan_stop = 1'b0;
        check("pair_busy", 32'(bus2.busy), 32'd0);
        check("pair_out", 32'(bus2.out), 32'd0);

        // reset mid-scan
        bus2.scan_start = 1'b1;
        tick;
        bus2.scan_start = 1'b0;
        tick;
        check("mid_scan_busy", 32'(bus2.busy), 32'd1);
        check("mid_scan_out", 32'(bus2.out), 32'h1);
        reset = 1'b1;
        tick;
        check("scan_reset_out", 32'(bus2.out), 32'd0);
        check("scan_reset_busy", 32'(bus2.busy), 32'd0);
        check("scan_reset_valid", 32'(bus2.out_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("scan_reset_ready", 32'(bus2.in_ready), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
